// File: rtl/tempsense_arbiter.sv
// ---------------------------------------------------------------------------
// tempsense_arbiter
//
// Purpose:
//   Shares the single TC77 read path (TempLoader) between NREQ independent
//   requesters (startup delay, fan control, status/readout). Active-low level
//   requests are granted round-robin. For the granted requester the block
//   issues one nLOAD pulse, follows the loader's nCOMPLETE handshake, and
//   returns the 14-bit result together with a one-cycle acknowledge. This is
//   the only driver of TempLoader's nLOAD.
//
// Parameters:
//   NREQ            number of requesters (2..8)
//   TIMEOUT_CYCLES  longest allowed loader transfer before it is aborted
//   CACHE_AGE       cache lifetime in cycles (only with TEMPSENSE_CACHE_EN)
//
// Optional feature macro:
//   TEMPSENSE_CACHE_EN  adds a result cache with an age counter. A request
//                       that finds a fresh, valid cache entry is answered
//                       from the cache without touching the loader.
//
// Ports:
//   MCLK          in   system clock, all logic on the rising edge
//   nRESET        in   synchronous active-low reset
//   nREQ          in   [NREQ] per-requester request, active low, level
//   nGNT          out  [NREQ] one-hot-low grant, held for the transaction
//   nACK          out  [NREQ] one-cycle low pulse ending the transaction
//   TEMPOUT       out  [14] result in TC77 format
//   TIMEOUT_FLAG  out  sticky high once any transfer timed out
//   TL_nLOAD      out  TempLoader nLOAD, single-cycle active-low pulse
//   TL_nCOMPLETE  in   TempLoader nCOMPLETE, low when transfer done
//   TL_DATA       in   [14] TempLoader TEMPDATA
// ---------------------------------------------------------------------------
module tempsense_arbiter #(
    parameter int unsigned NREQ           = 3,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_000_000,
    parameter logic [23:0] CACHE_AGE      = 24'd1_000_000
) (
    input  logic            MCLK,
    input  logic            nRESET,
    input  logic [NREQ-1:0] nREQ,
    output logic [NREQ-1:0] nGNT,
    output logic [NREQ-1:0] nACK,
    output logic [13:0]     TEMPOUT,
    output logic            TIMEOUT_FLAG,
    output logic            TL_nLOAD,
    input  logic            TL_nCOMPLETE,
    input  logic [13:0]     TL_DATA
);

    localparam int unsigned PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [23:0] TO_LAST = TIMEOUT_CYCLES - 24'd1;

    // S_HIT is only reachable when the cache is built; it delays the cached
    // answer by one cycle so nACK lands two cycles after the request sample.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ARM  = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4,
        S_HIT  = 3'd5
    } state_e;

    state_e            state_q,        state_d;
    logic [PTR_W-1:0]  rr_ptr_q,       rr_ptr_d;
    logic [NREQ-1:0]   gnt_q,          gnt_d;
    logic              tl_nload_q,     tl_nload_d;
    logic [13:0]       tempout_q,      tempout_d;
    logic              timeout_flag_q, timeout_flag_d;
    logic [23:0]       tcnt_q,         tcnt_d;

    logic              timed_out;
    logic              do_abort;

    // -----------------------------------------------------------------------
    // Round-robin search: candidate gi is requester (rr_ptr + gi) mod NREQ.
    // The lowest offset with a low request wins.
    // -----------------------------------------------------------------------
    logic [PTR_W:0]    cand_sum [NREQ];
    logic [PTR_W-1:0]  cand_idx [NREQ];
    logic              req_any;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  win_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, rr_ptr_q} + (PTR_W+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (PTR_W+1)'(NREQ))
                                ? PTR_W'(cand_sum[gi] - (PTR_W+1)'(NREQ))
                                : cand_sum[gi][PTR_W-1:0];
        end
    endgenerate

    always_comb begin
        req_any = 1'b0;
        win_idx = '0;
        // Walk from the farthest offset down so the nearest requester
        // overwrites any farther one.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (!nREQ[cand_idx[i]]) begin
                req_any = 1'b1;
                win_idx = cand_idx[i];
            end
        end
    end

    assign win_next  = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    assign timed_out = (tcnt_q == TO_LAST);

`ifdef TEMPSENSE_CACHE_EN
    // -----------------------------------------------------------------------
    // Result cache. Only completed conversions (bit0 set) are cached, so a
    // cache hit never hands back a "retry" value. A timeout invalidates it.
    // -----------------------------------------------------------------------
    logic [13:0] cache_q,       cache_d;
    logic        cache_valid_q, cache_valid_d;
    logic [23:0] age_q,         age_d;
    logic        cache_hit;

    assign cache_hit = cache_valid_q && (age_q < CACHE_AGE);

    always_comb begin
        cache_d       = cache_q;
        cache_valid_d = cache_valid_q;
        age_d         = (age_q >= CACHE_AGE) ? age_q : age_q + 24'd1;
        if ((state_q == S_WAIT) && !TL_nCOMPLETE && TL_DATA[0]) begin
            cache_d       = TL_DATA;
            cache_valid_d = 1'b1;
            age_d         = '0;
        end
        if (do_abort) begin
            cache_valid_d = 1'b0;
        end
    end

    always_ff @(posedge MCLK) begin
        if (!nRESET) begin
            cache_q       <= '0;
            cache_valid_q <= 1'b0;
            age_q         <= '0;
        end else begin
            cache_q       <= cache_d;
            cache_valid_q <= cache_valid_d;
            age_q         <= age_d;
        end
    end
`else
    // CACHE_AGE has no effect without the cache; this empty block keeps the
    // parameter referenced so both builds share one parameter list.
    generate
        if (CACHE_AGE == 24'd0) begin : g_cache_age_unused
        end
    endgenerate
`endif

    // -----------------------------------------------------------------------
    // Transaction FSM: next-state and register updates
    // -----------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        gnt_d          = gnt_q;
        tl_nload_d     = 1'b1;
        tempout_d      = tempout_q;
        timeout_flag_d = timeout_flag_q;
        tcnt_d         = tcnt_q;
        do_abort       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    rr_ptr_d       = win_next;
`ifdef TEMPSENSE_CACHE_EN
                    if (cache_hit) begin
                        state_d = S_HIT;
                    end else begin
                        tl_nload_d = 1'b0;
                        state_d    = S_LOAD;
                    end
`else
                    tl_nload_d = 1'b0;
                    state_d    = S_LOAD;
`endif
                end
            end

            S_LOAD: begin
                tcnt_d  = '0;
                state_d = S_ARM;
            end

            // A low nCOMPLETE here may be left over from the previous
            // transfer, so wait to see the loader go busy first.
            S_ARM: begin
                if (timed_out) begin
                    do_abort = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 24'd1;
                    if (TL_nCOMPLETE) begin
                        state_d = S_WAIT;
                    end
                end
            end

            // Completion wins over a timeout landing on the same edge.
            S_WAIT: begin
                if (!TL_nCOMPLETE) begin
                    tempout_d = TL_DATA;
                    state_d   = S_DONE;
                end else if (timed_out) begin
                    do_abort = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 24'd1;
                end
            end

`ifdef TEMPSENSE_CACHE_EN
            S_HIT: begin
                tempout_d = cache_q;
                state_d   = S_DONE;
            end
`endif

            S_DONE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Aborted transfer returns zero; bit0 = 0 tells consumers to retry.
        if (do_abort) begin
            tempout_d      = '0;
            timeout_flag_d = 1'b1;
            state_d        = S_DONE;
        end
    end

    always_ff @(posedge MCLK) begin
        if (!nRESET) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            gnt_q          <= '0;
            tl_nload_q     <= 1'b1;
            tempout_q      <= '0;
            timeout_flag_q <= 1'b0;
            tcnt_q         <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            gnt_q          <= gnt_d;
            tl_nload_q     <= tl_nload_d;
            tempout_q      <= tempout_d;
            timeout_flag_q <= timeout_flag_d;
            tcnt_q         <= tcnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: all decoded from registers, so they are glitch-free.
    // -----------------------------------------------------------------------
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_out
            assign nGNT[gi] = ~gnt_q[gi];
            assign nACK[gi] = ~(gnt_q[gi] & (state_q == S_DONE));
        end
    endgenerate

    assign TEMPOUT      = tempout_q;
    assign TIMEOUT_FLAG = timeout_flag_q;
    assign TL_nLOAD     = tl_nload_q;

endmodule

// File: tb/tb_tempsense_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tempsense_arbiter
//
// Directed bench for tempsense_arbiter (NREQ = 3, TIMEOUT_CYCLES = 100).
// A behavioural TempLoader answers each nLOAD pulse: optionally keeps a stale
// low nCOMPLETE for lm_pre cycles, goes busy for lm_busy cycles, then
// completes with lm_data (or never completes when lm_hang is set).
// ---------------------------------------------------------------------------
module tb_tempsense_arbiter;

    logic        MCLK;
    logic        nRESET;
    logic [2:0]  nREQ;
    logic [2:0]  nGNT;
    logic [2:0]  nACK;
    logic [13:0] TEMPOUT;
    logic        TIMEOUT_FLAG;
    logic        TL_nLOAD;
    logic        TL_nCOMPLETE;
    logic [13:0] TL_DATA;

    tempsense_arbiter #(
        .NREQ           (3),
        .TIMEOUT_CYCLES (24'd100),
        .CACHE_AGE      (24'd1000)
    ) dut (
        .MCLK         (MCLK),
        .nRESET       (nRESET),
        .nREQ         (nREQ),
        .nGNT         (nGNT),
        .nACK         (nACK),
        .TEMPOUT      (TEMPOUT),
        .TIMEOUT_FLAG (TIMEOUT_FLAG),
        .TL_nLOAD     (TL_nLOAD),
        .TL_nCOMPLETE (TL_nCOMPLETE),
        .TL_DATA      (TL_DATA)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    int vectors = 0;
    int errors  = 0;

    // loader model controls
    int          lm_pre  = 0;
    int          lm_busy = 3;
    logic [13:0] lm_data = '0;
    logic        lm_hang = 1'b0;

    // monitors
    int nload_lows = 0;
    int overlap    = 0;

    always @(negedge MCLK) begin
        if (TL_nLOAD === 1'b0) nload_lows++;
        if ($countones(~nGNT) > 1) overlap++;
    end

    // TempLoader model
    initial begin
        TL_nCOMPLETE = 1'b0;
        TL_DATA      = '0;
        forever begin
            @(posedge MCLK);
            #1;
            if (TL_nLOAD === 1'b0) begin
                if (lm_pre > 0) begin
                    repeat (lm_pre) @(posedge MCLK);
                    #1;
                end
                TL_nCOMPLETE = 1'b1;
                repeat (lm_busy) @(posedge MCLK);
                #1;
                if (!lm_hang) begin
                    TL_DATA      = lm_data;
                    TL_nCOMPLETE = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Ticks until some nACK is low (bounded). cyc counts edges from the
    // first edge after entry; gnt_seen is the first non-idle grant observed.
    task automatic wait_ack(input string tag, input int max_cyc, output int idx,
                            output int cyc, output logic [2:0] gnt_seen);
        int gnt_bad;
        cyc      = 0;
        idx      = -1;
        gnt_seen = 3'b111;
        gnt_bad  = 0;
        while (nACK === 3'b111 && cyc < max_cyc) begin
            tick();
            cyc++;
            if (gnt_seen === 3'b111) gnt_seen = nGNT;
            else if (nGNT !== gnt_seen) gnt_bad++;
        end
        for (int i = 0; i < 3; i++) if (nACK[i] === 1'b0) idx = i;
        check({tag, "_ack_seen"}, 32'($countones(~nACK)), 32'd1);
        check({tag, "_gnt_stable"}, gnt_bad, 0);
        $display("txn %s: ack idx=%0d after %0d cycles, TEMPOUT=%h", tag, idx, cyc, TEMPOUT);
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        repeat (2) tick();
        nRESET = 1'b1;
        tick();
    endtask

    logic [13:0] ctab   [4];
    int          corder [4];

    initial begin
        int          idx;
        int          cyc;
        int          base;
        int          ov_base;
        logic [2:0]  gseen;

        ctab   = '{14'h0111, 14'h0222, 14'h0333, 14'h0444};
        corder = '{0, 1, 2, 0};

        nRESET = 1'b0;
        nREQ   = 3'b111;
        repeat (3) tick();

        // ---- reset state ----
        check("rst_nGNT", nGNT, 3'b111);
        check("rst_nACK", nACK, 3'b111);
        check("rst_TL_nLOAD", TL_nLOAD, 1'b1);
        check("rst_TEMPOUT", TEMPOUT, 14'h0000);
        check("rst_TIMEOUT_FLAG", TIMEOUT_FLAG, 1'b0);
        nRESET = 1'b1;
        tick();

        // ---- single request from requester 1, 50-cycle transfer ----
        base    = nload_lows;
        lm_pre  = 0;
        lm_busy = 50;
        lm_data = 14'h0321;
        nREQ    = 3'b101;
        wait_ack("single", 200, idx, cyc, gseen);
        check("single_latency", cyc, 52);
        check("single_idx", idx, 1);
        check("single_gnt", gseen, 3'b101);
        check("single_nACK", nACK, 3'b101);
        check("single_TEMPOUT", TEMPOUT, 14'h0321);
        check("single_TIMEOUT_FLAG", TIMEOUT_FLAG, 1'b0);
        nREQ = 3'b111;
        tick();
        check("single_nACK_release", nACK, 3'b111);
        check("single_nGNT_release", nGNT, 3'b111);
        check("single_nload_pulses", nload_lows - base, 1);

        // ---- contention: all request; requester 0 re-requests once ----
        do_reset();
        base    = nload_lows;
        ov_base = overlap;
        lm_busy = 3;
        nREQ    = 3'b000;
        for (int k = 0; k < 4; k++) begin
            lm_data = ctab[k];
            wait_ack($sformatf("cont%0d", k), 100, idx, cyc, gseen);
            check($sformatf("cont%0d_idx", k), idx, corder[k]);
            check($sformatf("cont%0d_TEMPOUT", k), TEMPOUT, ctab[k]);
            if (k != 0) nREQ[corder[k]] = 1'b1;
            tick();
        end
        check("cont_nload_pulses", nload_lows - base, 4);
        check("cont_grant_overlap", overlap - ov_base, 0);

        // ---- timeout: loader never completes ----
        lm_hang = 1'b1;
        nREQ    = 3'b110;
        wait_ack("timeout", 300, idx, cyc, gseen);
        check("timeout_latency", cyc, 102);
        check("timeout_idx", idx, 0);
        check("timeout_TEMPOUT", TEMPOUT, 14'h0000);
        check("timeout_flag", TIMEOUT_FLAG, 1'b1);
        nREQ = 3'b111;
        tick();

        // ---- good transfer after timeout: flag stays sticky ----
        lm_hang = 1'b0;
        lm_data = 14'h0555;
        nREQ    = 3'b011;
        wait_ack("after_to", 100, idx, cyc, gseen);
        check("after_to_latency", cyc, 5);
        check("after_to_idx", idx, 2);
        check("after_to_TEMPOUT", TEMPOUT, 14'h0555);
        check("after_to_flag_sticky", TIMEOUT_FLAG, 1'b1);
        nREQ = 3'b111;
        tick();

        // ---- reset during WAIT ----
        lm_busy = 50;
        lm_data = 14'h3FFF;
        nREQ    = 3'b101;
        repeat (10) tick();
        check("midrst_pre_nGNT", nGNT, 3'b101);
        nRESET = 1'b0;
        tick();
        check("midrst_nGNT", nGNT, 3'b111);
        check("midrst_nACK", nACK, 3'b111);
        check("midrst_TL_nLOAD", TL_nLOAD, 1'b1);
        check("midrst_TEMPOUT", TEMPOUT, 14'h0000);
        check("midrst_flag", TIMEOUT_FLAG, 1'b0);
        nRESET = 1'b1;
        nREQ   = 3'b111;
        repeat (60) tick();
        check("midrst_orphan_ignored", TEMPOUT, 14'h0000);
        base    = nload_lows;
        lm_busy = 5;
        lm_data = 14'h0ABC;
        nREQ    = 3'b011;
        wait_ack("midrst_req2", 100, idx, cyc, gseen);
        check("midrst_req2_latency", cyc, 7);
        check("midrst_req2_idx", idx, 2);
        check("midrst_req2_TEMPOUT", TEMPOUT, 14'h0ABC);
        check("midrst_req2_pulses", nload_lows - base, 1);
        nREQ = 3'b111;
        tick();

        // ---- stale completion: nCOMPLETE low across the LOAD edge ----
        lm_pre  = 2;
        lm_busy = 10;
        lm_data = 14'h0F01;
        nREQ    = 3'b110;
        wait_ack("stale", 100, idx, cyc, gseen);
        check("stale_latency", cyc, 14);
        check("stale_idx", idx, 0);
        check("stale_TEMPOUT", TEMPOUT, 14'h0F01);
        nREQ = 3'b111;
        tick();
        check("stale_nACK_release", nACK, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
